// File: rtl/gcd_bin2bcd_pkg.sv
// Shared definitions for the gcd result BCD decoder and display path.
// FSM state encoding and the display digit count.
package gcd_bin2bcd_pkg;

    localparam int DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_bin2bcd_adj.sv
// Single BCD digit correction step for double dabble.
// A digit of 5 or more gets +3 so that the following shift carries correctly.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/gcd_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Feeds packed BCD digits of the gcd result to the seven-segment driver.
module gcd_bin2bcd
    import gcd_bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = DISP_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_sh_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;
    logic [ACC_W-1:0]   r_bcd;
    logic               r_ovf;

    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_acc_sh;
    logic               w_ovf_sh;
    logic               w_last;
    logic               w_load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // The bit leaving the top digit is a lost 10**DIGITS carry.
    assign w_acc_sh = {w_adj[ACC_W-2:0], r_sh_bin[BIN_W-1]};
    assign w_ovf_sh = r_ovf_acc | w_adj[ACC_W-1];
    assign w_last   = (r_cnt == CNT_W'(BIN_W - 1));
    assign w_load   = start && (r_state == IDLE || r_state == DONE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Results are latched on the final shift so they are valid during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_bin  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            r_sh_bin  <= bin_in;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_sh_bin  <= r_sh_bin << 1;
            r_acc     <= w_acc_sh;
            r_ovf_acc <= w_ovf_sh;
            r_cnt     <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_bcd <= w_acc_sh;
                r_ovf <= w_ovf_sh;
            end
        end
    end

    assign busy    = (r_state == SHIFT);
    assign done    = (r_state == DONE);
    assign bcd_out = r_bcd;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_gcd_bin2bcd.sv
// Self-checking bench for gcd_bin2bcd: latency, values, handshake, reset.
// Expected results come from an arithmetic model held in a scoreboard queue.
module tb_gcd_bin2bcd;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    gcd_bin2bcd #(.BIN_W(32), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        longint unsigned m;
        m = 64'(v) % 64'd10000;
        e.bcd = '0;
        for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 64'd10);
            m = m / 64'd10;
        end
        e.ovf = (v >= 32'd10000);
        return e;
    endfunction

    // Called on the negedge after the accepting edge; counts edges to done.
    task automatic wait_done(output int lat, output int bcy);
        lat = 1;
        bcy = 0;
        while (!done && lat < 200) begin
            if (busy) bcy++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done not seen within %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, bcd_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy, done, ovf, bcd_out);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_values();
        logic [31:0] vals [6];
        exp_t e;
        int lat, bcy;
        vals = '{32'd0, 32'd99, 32'd9999, 32'd10000, 32'hFFFF_FFFF, 32'd1234567};
        foreach (vals[k]) begin
            @(negedge clk);
            bin_in = vals[k];
            start  = 1'b1;
            sb.push_back(model(vals[k]));
            @(negedge clk);
            start  = 1'b0;
            bin_in = $urandom;
            wait_done(lat, bcy);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: value %0d", vals[k]);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (bcd_out !== e.bcd) begin
                    errors++;
                    $display("FAIL bcd_%0d: got %h want %h", vals[k], bcd_out, e.bcd);
                end
                if (ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL ovf_%0d: got %b want %b", vals[k], ovf, e.ovf);
                end
                if (lat != 33) begin
                    errors++;
                    $display("FAIL latency_%0d: got %0d want 33", vals[k], lat);
                end
            end
            checks++;
            if (bcy != 32) begin
                errors++;
                $display("FAIL busy_cycles_%0d: got %0d want 32", vals[k], bcy);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || bcd_out !== e.bcd) begin
                errors++;
                $display("FAIL hold_%0d: got done=%b bcd=%h want done=0 bcd=%h",
                         vals[k], done, bcd_out, e.bcd);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int lat, bcy, nd;
        @(negedge clk);
        bin_in = 32'd1234;
        start  = 1'b1;
        sb.push_back(model(32'd1234));
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        bin_in = 32'd5678;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 32'd0;
        wait_done(lat, bcy);
        e = sb.pop_front();
        checks++;
        if (bcd_out !== e.bcd || ovf !== e.ovf) begin
            errors++;
            $display("FAIL ignore_result: got %h/%b want %h/%b",
                     bcd_out, ovf, e.bcd, e.ovf);
        end
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL ignore_not_queued: got %0d active cycles want 0", nd);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat, bcy;
        @(negedge clk);
        bin_in = 32'd42;
        start  = 1'b1;
        sb.push_back(model(32'd42));
        @(negedge clk);
        wait_done(lat, bcy);
        e = sb.pop_front();
        checks++;
        if (bcd_out !== e.bcd) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", bcd_out, e.bcd);
        end
        bin_in = 32'd77;
        sb.push_back(model(32'd77));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bcd_out !== e.bcd) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b bcd=%h want busy=1 bcd=%h",
                     busy, bcd_out, e.bcd);
        end
        wait_done(lat, bcy);
        e = sb.pop_front();
        checks += 2;
        if (lat != 33) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 33", lat);
        end
        if (bcd_out !== e.bcd) begin
            errors++;
            $display("FAIL b2b_second: got %h want %h", bcd_out, e.bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat, bcy, nd;
        @(negedge clk);
        bin_in = 32'd9999;
        start  = 1'b1;
        sb.push_back(model(32'd9999));
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({busy, done, ovf, bcd_out} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy, done, ovf, bcd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done cycles want 0", nd);
        end
        bin_in = 32'd12;
        start  = 1'b1;
        sb.push_back(model(32'd12));
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcy);
        e = sb.pop_front();
        checks++;
        if (bcd_out !== e.bcd || ovf !== e.ovf || lat != 33) begin
            errors++;
            $display("FAIL after_reset: got %h/%b lat %0d want %h/%b lat 33",
                     bcd_out, ovf, lat, e.bcd, e.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
